jb_affine_out: RTL and testbench

JB_AFFINE_OUT -- requirements
Module: jb_affine_out

---
 rtl/bn128_pkg.sv | 44 ++++
 rtl/fe_inv_seq.sv | 97 +++++++++
 rtl/jb_affine_out.sv | 167 ++++++++++++++++
 tb/tb_jb_affine_out.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn128_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bn128_pkg
//  Purpose  : Shared BN128 base-field definitions. Provides the field width,
//             the modulus P, the Montgomery radix exponent (R = 2^MONT_BITS),
//             the field-element type, Jacobian/affine point types and the
//             state encoding used by the affine-conversion block.
//  Revision : 1.0 - initial release
// ============================================================================
package bn128_pkg;

    localparam int DAT_BITS  = 254;
    localparam int MONT_BITS = 254;

    typedef logic [DAT_BITS-1:0] fe_t;

    // The modulus occupies 254 bits; it is written as a 256-bit literal and
    // sliced so the literal needs no truncation.
    localparam logic [255:0] P_WIDE =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
    localparam fe_t P      = P_WIDE[DAT_BITS-1:0];
    localparam fe_t FE_ONE = fe_t'(1);

    typedef struct packed {
        fe_t z;
        fe_t y;
        fe_t x;
    } jb_point_t;

    typedef struct packed {
        fe_t y;
        fe_t x;
    } af_point_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_REQ  = 3'd1,
        MUL_WAIT = 3'd2,
        INV      = 3'd3,
        OUT      = 3'd4
    } aff_state_t;

endpackage : bn128_pkg
`default_nettype wire

// File: rtl/fe_inv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fe_inv_seq
//  Purpose  : Sequential modular inverse (normal form) over the BN128 base
//             field using the binary extended Euclidean algorithm, one
//             halving or subtract-and-halve step per clock.
//  Ports    : i_clk, i_rst (async, active high)
//             i_start - one-cycle pulse, latches i_a and begins inversion
//             i_a     - operand, must be in [1, P)
//             o_res   - i_a^-1 mod P, valid when o_done pulses
//             o_done  - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module fe_inv_seq
    import bn128_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  fe_t  i_a,
    output fe_t  o_res,
    output logic o_done
);

    localparam int W = DAT_BITS + 1;
    typedef logic [W-1:0] wide_t;
    localparam wide_t P_W = {1'b0, P};

    // x/2 mod P for x in [0, P): odd values get P added first. The extra
    // bit keeps x+P (< 2^255) from overflowing.
    function automatic wide_t half_mod(input wide_t x);
        wide_t s;
        s = x[0] ? (x + P_W) : x;
        return s >> 1;
    endfunction

    // (a - b) mod P for a, b in [0, P).
    function automatic wide_t sub_mod(input wide_t a, input wide_t b);
        return (a >= b) ? (a - b) : (a + P_W - b);
    endfunction

    // Invariants while busy: x1*a == u and x2*a == v (mod P).
    wide_t u, v, x1, x2;
    logic  busy;
    fe_t   res;
    logic  done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            u    <= '0;
            v    <= '0;
            x1   <= '0;
            x2   <= '0;
            busy <= 1'b0;
            res  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (i_start) begin
                u    <= {1'b0, i_a};
                v    <= P_W;
                x1   <= wide_t'(1);
                x2   <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (u == wide_t'(1)) begin
                    res  <= x1[DAT_BITS-1:0];
                    done <= 1'b1;
                    busy <= 1'b0;
                end else if (v == wide_t'(1)) begin
                    res  <= x2[DAT_BITS-1:0];
                    done <= 1'b1;
                    busy <= 1'b0;
                end else if (!u[0]) begin
                    u  <= u >> 1;
                    x1 <= half_mod(x1);
                end else if (!v[0]) begin
                    v  <= v >> 1;
                    x2 <= half_mod(x2);
                end else if (u >= v) begin
                    // Both odd: the difference is even, so halve it in the
                    // same cycle to guarantee one bit of progress per step.
                    u  <= (u - v) >> 1;
                    x1 <= half_mod(sub_mod(x1, x2));
                end else begin
                    v  <= (v - u) >> 1;
                    x2 <= half_mod(sub_mod(x2, x1));
                end
            end
        end
    end

    assign o_res  = res;
    assign o_done = done;

endmodule : fe_inv_seq
`default_nettype wire

// File: rtl/jb_affine_out.sv
`default_nettype none
// ============================================================================
//  Module   : jb_affine_out
//  Purpose  : Converts a Jacobian point in Montgomery form to an affine point
//             in normal form: (x/z^2, y/z^3). Uses an external shared
//             Montgomery multiplier (a*b*2^-254 mod P) and the fe_inv_seq
//             inverter. z == 0 yields the point at infinity.
//  Ports    : i_clk, i_rst (async, active high)
//             i_pt/i_val/o_rdy      - input point handshake
//             o_af/o_inf/o_val/i_rdy - result handshake
//             o_mul_a/o_mul_b/o_mul_val/i_mul_rdy - multiplier request
//             i_mul_res/i_mul_val   - multiplier response
//  Revision : 1.0 - initial release
// ============================================================================
module jb_affine_out
    import bn128_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  jb_point_t i_pt,
    input  logic      i_val,
    output logic      o_rdy,
    output af_point_t o_af,
    output logic      o_inf,
    output logic      o_val,
    input  logic      i_rdy,
    output fe_t       o_mul_a,
    output fe_t       o_mul_b,
    output logic      o_mul_val,
    input  logic      i_mul_rdy,
    input  fe_t       i_mul_res,
    input  logic      i_mul_val
);

    aff_state_t state, next_state;
    logic [2:0] step;
    fe_t        xm, ym, zm;
    fe_t        tmp;        // z2m, then z3m, then z3
    fe_t        i3, i2, ax, ay;
    logic       inf;
    logic       inv_start;
    fe_t        inv_res;
    logic       inv_done;
    fe_t        op_a, op_b;

    // Multiplier program operands, indexed by step.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (step)
            3'd0:    begin op_a = zm;  op_b = zm;     end
            3'd1:    begin op_a = tmp; op_b = zm;     end
            3'd2:    begin op_a = tmp; op_b = FE_ONE; end  // leave Montgomery form
            3'd3:    begin op_a = zm;  op_b = i3;     end
            3'd4:    begin op_a = xm;  op_b = i2;     end
            3'd5:    begin op_a = ym;  op_b = i3;     end
            default: begin op_a = '0;  op_b = '0;     end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        o_rdy      = 1'b0;
        o_val      = 1'b0;
        o_mul_val  = 1'b0;
        o_mul_a    = '0;
        o_mul_b    = '0;
        inv_start  = 1'b0;
        case (state)
            IDLE: begin
                o_rdy = 1'b1;
                if (i_val) next_state = (i_pt.z == '0) ? OUT : MUL_REQ;
            end
            MUL_REQ: begin
                o_mul_val = 1'b1;
                o_mul_a   = op_a;
                o_mul_b   = op_b;
                if (i_mul_rdy) next_state = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (i_mul_val) begin
                    if (step == 3'd2) begin
                        // z3 goes straight from the multiplier into the inverter.
                        next_state = INV;
                        inv_start  = 1'b1;
                    end else if (step == 3'd5) begin
                        next_state = OUT;
                    end else begin
                        next_state = MUL_REQ;
                    end
                end
            end
            INV: begin
                if (inv_done) next_state = MUL_REQ;
            end
            OUT: begin
                o_val = 1'b1;
                if (i_rdy) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            step <= '0;
            xm   <= '0;
            ym   <= '0;
            zm   <= '0;
            tmp  <= '0;
            i3   <= '0;
            i2   <= '0;
            ax   <= '0;
            ay   <= '0;
            inf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_val) begin
                        xm   <= i_pt.x;
                        ym   <= i_pt.y;
                        zm   <= i_pt.z;
                        step <= '0;
                        ax   <= '0;
                        ay   <= '0;
                        inf  <= (i_pt.z == '0);
                    end
                end
                MUL_WAIT: begin
                    if (i_mul_val) begin
                        step <= step + 3'd1;
                        case (step)
                            3'd0, 3'd1, 3'd2: tmp <= i_mul_res;
                            3'd3:             i2  <= i_mul_res;
                            3'd4:             ax  <= i_mul_res;
                            3'd5:             ay  <= i_mul_res;
                            default:          ;
                        endcase
                    end
                end
                INV: begin
                    if (inv_done) i3 <= inv_res;
                end
                default: ;
            endcase
        end
    end

    fe_inv_seq u_inv (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (inv_start),
        .i_a     (i_mul_res),
        .o_res   (inv_res),
        .o_done  (inv_done)
    );

    assign o_af  = '{y: ay, x: ax};
    assign o_inf = inf;

endmodule : jb_affine_out
`default_nettype wire

// File: tb/tb_jb_affine_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jb_affine_out
//  Purpose  : Self-checking bench for jb_affine_out with a behavioural
//             Montgomery multiplier responder and a modular-arithmetic
//             reference model (x/z^2, y/z^3 via Fermat inversion).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jb_affine_out;
    import bn128_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    jb_point_t pt;
    logic      in_val;
    logic      up_rdy;
    af_point_t af;
    logic      inf;
    logic      out_val;
    logic      dn_rdy;
    fe_t       mul_a, mul_b;
    logic      mul_val;
    logic      mul_rdy;
    fe_t       mul_res;
    logic      mul_res_val;

    always #5 clk = ~clk;

    jb_affine_out dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_pt      (pt),
        .i_val     (in_val),
        .o_rdy     (up_rdy),
        .o_af      (af),
        .o_inf     (inf),
        .o_val     (out_val),
        .i_rdy     (dn_rdy),
        .o_mul_a   (mul_a),
        .o_mul_b   (mul_b),
        .o_mul_val (mul_val),
        .i_mul_rdy (mul_rdy),
        .i_mul_res (mul_res),
        .i_mul_val (mul_res_val)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic fe_t mmul(input fe_t a, input fe_t b);
        logic [511:0] t;
        t = 512'(a) * 512'(b);
        return fe_t'(t % 512'(P));
    endfunction

    function automatic fe_t mpow(input fe_t b, input fe_t e);
        fe_t r;
        r = FE_ONE;
        for (int i = DAT_BITS - 1; i >= 0; i--) begin
            r = mmul(r, r);
            if (e[i]) r = mmul(r, b);
        end
        return r;
    endfunction

    function automatic fe_t to_mont(input fe_t x);
        logic [511:0] t;
        t = 512'(x) << MONT_BITS;
        return fe_t'(t % 512'(P));
    endfunction

    function automatic fe_t rnd();
        logic [255:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) t = {t[223:0], 32'($urandom)};
        return t[DAT_BITS-1:0] % P;
    endfunction

    fe_t rinv;   // 2^-254 mod P

    // ---------------- multiplier responder ----------------
    int  rdy_delay     = 0;
    int  res_delay     = 0;
    int  req_count     = 0;
    int  mulval_cycles = 0;
    int  stable_err    = 0;
    bit  stray         = 1'b0;

    initial begin
        bit  pending;
        bit  have_req;
        int  waitc;
        int  lat;
        fe_t ha, hb, pres;
        pending  = 1'b0;
        have_req = 1'b0;
        waitc    = 0;
        lat      = 0;
        ha       = '0;
        hb       = '0;
        pres     = '0;
        mul_rdy     = 1'b0;
        mul_res_val = 1'b0;
        mul_res     = '0;
        forever begin
            @(negedge clk);
            mul_rdy     = 1'b0;
            mul_res_val = 1'b0;
            mul_res     = rnd();          // junk unless flagged valid
            if (mul_val) mulval_cycles++;
            if (rst) begin
                pending  = 1'b0;
                have_req = 1'b0;
            end else if (pending) begin
                if (lat == 0) begin
                    mul_res_val = 1'b1;
                    mul_res     = pres;
                    pending     = 1'b0;
                end else begin
                    lat--;
                end
            end else if (stray) begin
                mul_res_val = 1'b1;
                stray       = 1'b0;
            end else if (mul_val) begin
                if (!have_req) begin
                    have_req = 1'b1;
                    ha       = mul_a;
                    hb       = mul_b;
                    waitc    = 0;
                end else if (mul_a !== ha || mul_b !== hb) begin
                    stable_err++;
                end
                if (waitc >= rdy_delay) begin
                    mul_rdy  = 1'b1;
                    pres     = mmul(mmul(ha, hb), rinv);
                    pending  = 1'b1;
                    lat      = res_delay;
                    have_req = 1'b0;
                    req_count++;
                end else begin
                    waitc++;
                end
            end
        end
    end

    // ---------------- one point through the block ----------------
    task automatic run_pt(input string tag, input fe_t x, input fe_t y, input fe_t z,
                          input int hold, output int lat, output int reqs);
        fe_t zi, ex, ey;
        af_point_t snap;
        int n, bad;
        if (z == '0) begin
            ex = '0;
            ey = '0;
        end else begin
            zi = mpow(z, P - fe_t'(2));
            ex = mmul(x, mmul(zi, zi));
            ey = mmul(y, mmul(zi, mmul(zi, zi)));
        end
        req_count     = 0;
        mulval_cycles = 0;
        stable_err    = 0;
        n = 0;
        while (!up_rdy && n < 2000) begin @(negedge clk); n++; end
        check({tag, ".in_rdy"}, 256'(up_rdy), 256'(1'b1));
        pt = '{z: to_mont(z), y: to_mont(y), x: to_mont(x)};
        in_val = 1'b1;
        @(negedge clk);
        in_val = 1'b0;
        check({tag, ".rdy_drop"}, 256'(up_rdy), 256'(1'b0));
        lat = 1;
        while (!out_val && lat < 4000) begin @(negedge clk); lat++; end
        check({tag, ".o_val"}, 256'(out_val), 256'(1'b1));
        check({tag, ".ax"},  256'(af.x), 256'(ex));
        check({tag, ".ay"},  256'(af.y), 256'(ey));
        check({tag, ".inf"}, 256'(inf),  256'(z == '0));
        if (hold > 0) begin
            snap = af;
            bad  = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (af !== snap || up_rdy !== 1'b0 || out_val !== 1'b1) bad++;
            end
            check({tag, ".hold_stable"}, 256'(bad), 256'(0));
        end
        dn_rdy = 1'b1;
        @(negedge clk);
        dn_rdy = 1'b0;
        check({tag, ".val_drop"}, 256'(out_val), 256'(1'b0));
        check({tag, ".rdy_back"}, 256'(up_rdy),  256'(1'b1));
        check({tag, ".op_stable"}, 256'(stable_err), 256'(0));
        reqs = req_count;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int  lat, reqs, n;
        fe_t rx, ry, rz;
        rst    = 1'b1;
        pt     = '0;
        in_val = 1'b0;
        dn_rdy = 1'b0;
        rinv   = mpow(to_mont(FE_ONE), P - fe_t'(2));
        repeat (3) @(negedge clk);
        check("rst.o_rdy",     256'(up_rdy),  256'(1'b1));
        check("rst.o_val",     256'(out_val), 256'(1'b0));
        check("rst.o_inf",     256'(inf),     256'(1'b0));
        check("rst.o_af",      256'(af),      256'(0));
        check("rst.o_mul_val", 256'(mul_val), 256'(1'b0));
        check("rst.o_mul_ab",  256'({mul_a, mul_b}), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // G1 in Montgomery form
        run_pt("g1", fe_t'(1), fe_t'(2), fe_t'(1), 0, lat, reqs);
        check("g1.reqs", 256'(reqs), 256'(6));
        check("g1.latency", 256'(lat <= 6 * 4 + 2 * DAT_BITS + 6), 256'(1'b1));

        // Scaled representation of G1
        run_pt("g1z2", fe_t'(4), fe_t'(16), fe_t'(2), 0, lat, reqs);
        check("g1z2.reqs", 256'(reqs), 256'(6));

        // Point at infinity
        run_pt("inf", rnd(), rnd(), '0, 0, lat, reqs);
        check("inf.mul_val_cycles", 256'(mulval_cycles), 256'(0));
        check("inf.latency",        256'(lat <= 2), 256'(1'b1));

        // Slow multiplier: operands held, result unchanged
        rdy_delay = 10;
        res_delay = 5;
        run_pt("slow", fe_t'(1), fe_t'(2), fe_t'(1), 0, lat, reqs);
        check("slow.reqs", 256'(reqs), 256'(6));
        check("slow.latency", 256'(lat <= 6 * 20 + 2 * DAT_BITS + 6), 256'(1'b1));
        rdy_delay = 0;
        res_delay = 0;

        // Downstream back-pressure
        run_pt("hold", fe_t'(4), fe_t'(16), fe_t'(2), 20, lat, reqs);

        // Reset in the middle of inversion
        pt = '{z: to_mont(FE_ONE), y: to_mont(fe_t'(2)), x: to_mont(FE_ONE)};
        req_count = 0;
        in_val = 1'b1;
        @(negedge clk);
        in_val = 1'b0;
        n = 0;
        while (req_count < 3 && n < 200) begin @(negedge clk); n++; end
        check("rstmid.reached_inv", 256'(req_count >= 3), 256'(1'b1));
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.o_val", 256'(out_val), 256'(1'b0));
        check("rstmid.o_rdy", 256'(up_rdy),  256'(1'b1));
        rst = 1'b0;
        stray = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid.stray_o_rdy", 256'(up_rdy),  256'(1'b1));
        check("rstmid.stray_o_val", 256'(out_val), 256'(1'b0));
        run_pt("after_rst", fe_t'(1), fe_t'(2), fe_t'(1), 0, lat, reqs);

        // Boundary operands
        run_pt("pm1", P - fe_t'(1), P - fe_t'(1), P - fe_t'(1), 0, lat, reqs);
        run_pt("y0",  fe_t'(7), '0, P - fe_t'(2), 0, lat, reqs);

        // Random points with random handshake delays
        for (int k = 0; k < 4; k++) begin
            rx = rnd();
            ry = rnd();
            rz = rnd();
            if (rz == '0) rz = FE_ONE;
            rdy_delay = int'($urandom_range(0, 3));
            res_delay = int'($urandom_range(0, 3));
            run_pt("rand", rx, ry, rz, int'($urandom_range(0, 3)), lat, reqs);
            check("rand.reqs", 256'(reqs), 256'(6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_jb_affine_out
`default_nettype wire
